symbol_store_ctrl: RTL and testbench
====================================

// Module: symbol_store_ctrl
// PURPOSE
// Controller for the 512x8 single-port symbol store in the 64-QAM modulator.
// Shares one memory port between the IQ symbol writer (modulator output, {I,Q} nibbles) and the SPI readback path.
// Owns the write pointer, fill count, full/overflow status and round-robin arbitration; drives the RAM port.
// PARAMETERS
// DEPTH    512  store depth in symbols
// ADDR_W   9    address width, log2(DEPTH)
// DATA_W   8    word width, {I_data,Q_data}
// WRAP_EN  0    1: write pointer wraps when full; 0: stop accepting when full
// PORTS
// sym_clk      in   1       symbol clock, rising edge
// rst_sym      in   1       async active-high reset
// clear        in   1       sync clear of pointer, count, overflow
// iq_valid     in   1       symbol available on I_data/Q_data
// I_data       in   4       in-phase symbol nibble
// Q_data       in   4       quadrature symbol nibble
// iq_ready     out  1       symbol accepted this cycle when iq_valid&iq_ready
// spi_rd_req   in   1       read request, level; held high until spi_rd_ack
// spi_rd_addr  in   ADDR_W  read address, sampled at grant
// spi_rd_ack   out  1       1-cycle pulse; spi_rd_data valid that cycle and held after
// spi_rd_data  out  DATA_W  read data
// mem_en       out  1       RAM enable
// mem_we       out  1       RAM write enable
// mem_addr     out  ADDR_W  RAM address
// mem_wdata    out  DATA_W  RAM write data
// mem_rdata    in   DATA_W  RAM read data, valid 1 cycle after mem_en&!mem_we
// wr_count     out  ADDR_W+1 symbols stored, saturates at DEPTH
// store_full   out  1       wr_count==DEPTH
// overflow     out  1       sticky: iq_valid seen while full and WRAP_EN=0
// BEHAVIOUR
// - Reset: state IDLE; wr_ptr, wr_count, overflow, spi_rd_ack, spi_rd_data, mem_* all 0; last_grant=READ so write wins first contention.
// - iq_ready is combinational: IDLE & grant_wr & (!store_full | WRAP_EN) & !clear; forced 0 while rst_sym high.
// - FSM: IDLE, WR, RD, RD_WAIT. mem_* outputs registered.
// - IDLE: grant_wr = !spi_rd_req | last_grant==READ. grant_rd = spi_rd_req & !(iq_valid & iq_ready).
// - IDLE write accept: capture {I_data,Q_data}, go WR. WR: mem_en=1, mem_we=1, addr=wr_ptr; wr_ptr++, count++; last_grant=WRITE; go IDLE.
// - Write throughput: 1 symbol per 2 cycles.
// - IDLE read grant: capture spi_rd_addr, go RD. RD: mem_en=1, mem_we=0; go RD_WAIT.
// - RD_WAIT: register mem_rdata into spi_rd_data, last_grant=READ; go IDLE.
// - spi_rd_ack pulses in the following IDLE cycle. Latency from req seen in IDLE (cycle T) to ack: T+3.
// - Ack cycle: spi_rd_req is ignored for arbitration. The requester drops or re-issues it next cycle.
// - Full, WRAP_EN=0: iq_ready=0. iq_valid while full sets overflow. Reads continue normally.
// - Full, WRAP_EN=1: wr_ptr wraps DEPTH-1 -> 0. wr_count stays at DEPTH. overflow never set.
// - wr_ptr wrap: modulo DEPTH always; count increment saturates.
// - Reads at addresses >= wr_count are not checked; they return RAM contents.
// - clear: has priority over increment. An in-flight WR completes at the old address, then wr_ptr/wr_count/overflow = 0. A read in progress completes normally.
// - Reset mid-operation: access is abandoned and mem_en drops immediately. A pending SPI read gets no ack; SPI must re-request.
// STRUCTURE
// - Shared header qam_defs.vh: SYM_DEPTH, SYM_ADDR_W, SYM_DATA_W, FSM state encodings (2-bit), grant encoding.
// - Sub-module rr_arb2: 2-requester round-robin arbiter, last_grant register inside. The rest lives in this module.
// TESTING
// - Reset, then iq_valid=1 with I=4'hA, Q=4'h5 -> mem write of 8'hA5 to addr 0 two cycles later; wr_count=1.
// - Stream 512 symbols, WRAP_EN=0 -> store_full=1 at count 512; iq_ready=0; extra iq_valid sets overflow; clear zeroes all three.
// - WRAP_EN=1, write 513 symbols -> the 513th goes to addr 0; wr_count=512; overflow=0.
// - Preload addr 9'h07F=8'h3C, spi_rd_req with that addr -> spi_rd_ack pulse 3 cycles after grant, spi_rd_data=8'h3C.
// - iq_valid and spi_rd_req held together -> grants alternate W,R,W,R. No write is lost; every read is acked.
// - Assert rst_sym during RD_WAIT -> mem_en=0 at once, no ack, state IDLE. A re-issued read completes correctly.

Source files
------------

// File: rtl/symbol_store_ctrl_pkg.sv
// Shared sizes and encodings for the QAM symbol store controller.
package symbol_store_ctrl_pkg;

  localparam int SYM_DEPTH  = 512;
  localparam int SYM_ADDR_W = 9;
  localparam int SYM_DATA_W = 8;

  localparam logic [SYM_ADDR_W:0] SYM_CNT_FULL = (SYM_ADDR_W+1)'(SYM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD      = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_e;

  typedef enum logic {
    GNT_WRITE = 1'b0,
    GNT_READ  = 1'b1
  } grant_e;

endpackage

// File: rtl/symbol_store_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter (symbol writer vs SPI readback).
module symbol_store_ctrl_rr_arb2
  import symbol_store_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic wr_req_i,
  input  logic rd_req_i,
  input  logic wr_done_i,
  input  logic rd_done_i,
  output logic gnt_wr_o,
  output logic gnt_rd_o
);

  grant_e last_grant_q;
  grant_e last_grant_d;

  // Write wins a tie when the previous access was a read.
  assign gnt_wr_o = !rd_req_i || (last_grant_q == GNT_READ);
  assign gnt_rd_o = rd_req_i && !(wr_req_i && gnt_wr_o);

  always_comb begin
    last_grant_d = last_grant_q;
    if (wr_done_i)      last_grant_d = GNT_WRITE;
    else if (rd_done_i) last_grant_d = GNT_READ;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_grant_q <= GNT_READ;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/symbol_store_ctrl.sv
// Shares the single-port 512x8 symbol RAM between the IQ symbol writer and SPI readback.
module symbol_store_ctrl
  import symbol_store_ctrl_pkg::*;
#(
  parameter bit WRAP_EN = 1'b0
) (
  input  logic                  sym_clk_i,
  input  logic                  rst_sym_i,
  input  logic                  clear_i,
  input  logic                  iq_valid_i,
  input  logic [3:0]            i_data_i,
  input  logic [3:0]            q_data_i,
  output logic                  iq_ready_o,
  input  logic                  spi_rd_req_i,
  input  logic [SYM_ADDR_W-1:0] spi_rd_addr_i,
  output logic                  spi_rd_ack_o,
  output logic [SYM_DATA_W-1:0] spi_rd_data_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [SYM_ADDR_W-1:0] mem_addr_o,
  output logic [SYM_DATA_W-1:0] mem_wdata_o,
  input  logic [SYM_DATA_W-1:0] mem_rdata_i,
  output logic [SYM_ADDR_W:0]   wr_count_o,
  output logic                  store_full_o,
  output logic                  overflow_o
);

  state_e                  state_q, state_d;
  logic [SYM_ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [SYM_ADDR_W:0]     wr_count_q, wr_count_d;
  logic                    overflow_q, overflow_d;
  logic                    ack_q, ack_d;
  logic [SYM_DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_we_q, mem_we_d;
  logic [SYM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [SYM_DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic idle, wr_space, wr_req, rd_req, gnt_wr, gnt_rd, accept;

  assign idle         = (state_q == ST_IDLE);
  assign store_full_o = (wr_count_q == SYM_CNT_FULL);
  assign wr_space     = !store_full_o || WRAP_EN;
  assign wr_req       = idle && iq_valid_i && wr_space && !clear_i && !rst_sym_i;
  // The request is still high in its own ack cycle; it must not win a second read.
  assign rd_req       = idle && spi_rd_req_i && !ack_q;
  assign iq_ready_o   = idle && gnt_wr && wr_space && !clear_i && !rst_sym_i;
  assign accept       = iq_valid_i && iq_ready_o;

  symbol_store_ctrl_rr_arb2 u_arb (
    .clk_i     (sym_clk_i),
    .rst_i     (rst_sym_i),
    .wr_req_i  (wr_req),
    .rd_req_i  (rd_req),
    .wr_done_i (state_q == ST_WR),
    .rd_done_i (state_q == ST_RD_WAIT),
    .gnt_wr_o  (gnt_wr),
    .gnt_rd_o  (gnt_rd)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_count_d  = wr_count_q;
    overflow_d  = overflow_q;
    ack_d       = 1'b0;
    rd_data_d   = rd_data_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_WR;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr_q;
          mem_wdata_d = {i_data_i, q_data_i};
        end else if (gnt_rd) begin
          state_d    = ST_RD;
          mem_en_d   = 1'b1;
          mem_addr_d = spi_rd_addr_i;
        end
      end
      ST_WR: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (wr_count_q != SYM_CNT_FULL) wr_count_d = wr_count_q + 1'b1;
        state_d = ST_IDLE;
      end
      ST_RD: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        rd_data_d = mem_rdata_i;
        ack_d     = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (iq_valid_i && store_full_o && !WRAP_EN) overflow_d = 1'b1;
    // Clear lands after any in-flight write has already been issued at the old address.
    if (clear_i) begin
      wr_ptr_d   = '0;
      wr_count_d = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge sym_clk_i or posedge rst_sym_i) begin
    if (rst_sym_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      wr_count_q  <= '0;
      overflow_q  <= 1'b0;
      ack_q       <= 1'b0;
      rd_data_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_count_q  <= wr_count_d;
      overflow_q  <= overflow_d;
      ack_q       <= ack_d;
      rd_data_q   <= rd_data_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign spi_rd_ack_o  = ack_q;
  assign spi_rd_data_o = rd_data_q;
  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign wr_count_o    = wr_count_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_symbol_store_ctrl.sv
// Scoreboard bench for symbol_store_ctrl: one non-wrapping and one wrapping instance.
module tb_symbol_store_ctrl;

  typedef struct packed {
    logic       we;
    logic [8:0] addr;
    logic [7:0] data;
  } op_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       iq_valid0 = 1'b0, iq_valid1 = 1'b0;
  logic [3:0] i_data = 4'h0, q_data = 4'h0;
  logic       spi_rd_req0 = 1'b0, spi_rd_req1 = 1'b0;
  logic [8:0] spi_rd_addr = 9'h0;
  logic [7:0] mem_rdata1 = 8'h00;

  logic       iq_ready0, iq_ready1, spi_rd_ack0, spi_rd_ack1;
  logic [7:0] spi_rd_data0, spi_rd_data1;
  logic       mem_en0, mem_en1, mem_we0, mem_we1;
  logic [8:0] mem_addr0, mem_addr1;
  logic [7:0] mem_wdata0, mem_wdata1, mem_rdata0;
  logic [9:0] wr_count0, wr_count1;
  logic       store_full0, store_full1, overflow0, overflow1;

  logic       pre_we = 1'b0;
  logic [8:0] pre_addr = 9'h0;
  logic [7:0] pre_data = 8'h0;
  logic [7:0] ram0 [512];

  op_t        opq0[$];
  op_t        opq1[$];
  logic [7:0] rdq[$];
  logic [8:0] mptr [2];

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  symbol_store_ctrl #(.WRAP_EN(1'b0)) dut0 (
    .sym_clk_i(clk), .rst_sym_i(rst), .clear_i(clear),
    .iq_valid_i(iq_valid0), .i_data_i(i_data), .q_data_i(q_data), .iq_ready_o(iq_ready0),
    .spi_rd_req_i(spi_rd_req0), .spi_rd_addr_i(spi_rd_addr),
    .spi_rd_ack_o(spi_rd_ack0), .spi_rd_data_o(spi_rd_data0),
    .mem_en_o(mem_en0), .mem_we_o(mem_we0), .mem_addr_o(mem_addr0),
    .mem_wdata_o(mem_wdata0), .mem_rdata_i(mem_rdata0),
    .wr_count_o(wr_count0), .store_full_o(store_full0), .overflow_o(overflow0)
  );

  symbol_store_ctrl #(.WRAP_EN(1'b1)) dut1 (
    .sym_clk_i(clk), .rst_sym_i(rst), .clear_i(clear),
    .iq_valid_i(iq_valid1), .i_data_i(i_data), .q_data_i(q_data), .iq_ready_o(iq_ready1),
    .spi_rd_req_i(spi_rd_req1), .spi_rd_addr_i(spi_rd_addr),
    .spi_rd_ack_o(spi_rd_ack1), .spi_rd_data_o(spi_rd_data1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
    .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1),
    .wr_count_o(wr_count1), .store_full_o(store_full1), .overflow_o(overflow1)
  );

  // Behavioural RAM behind dut0 with a backdoor preload port.
  always @(posedge clk) begin
    if (pre_we) ram0[pre_addr] <= pre_data;
    else if (mem_en0) begin
      if (mem_we0) ram0[mem_addr0] <= mem_wdata0;
      else         mem_rdata0 <= ram0[mem_addr0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: every RAM access and every ack must match the next expected entry.
  always @(negedge clk) begin
    op_t e;
    if (mem_en0) begin
      if (opq0.size() == 0) chk("dut0 unexpected mem op", {14'h0, mem_we0, mem_addr0, mem_wdata0}, 32'hFFFF_FFFF);
      else begin
        e = opq0.pop_front();
        chk("dut0 mem op", {mem_we0, mem_addr0, mem_we0 ? mem_wdata0 : 8'h00},
            {e.we, e.addr, e.we ? e.data : 8'h00});
      end
    end
    if (spi_rd_ack0) begin
      if (rdq.size() == 0) chk("dut0 unexpected ack", {24'h0, spi_rd_data0}, 32'hFFFF_FFFF);
      else chk("dut0 rd data", spi_rd_data0, rdq.pop_front());
    end
    if (mem_en1) begin
      if (opq1.size() == 0) chk("dut1 unexpected mem op", {14'h0, mem_we1, mem_addr1, mem_wdata1}, 32'hFFFF_FFFF);
      else begin
        e = opq1.pop_front();
        chk("dut1 mem op", {mem_we1, mem_addr1, mem_wdata1}, {e.we, e.addr, e.data});
      end
    end
    if (spi_rd_ack1) chk("dut1 unexpected ack", 32'h1, 32'h0);
  end

  task automatic set_iq(input logic [7:0] d);
    i_data = d[7:4];
    q_data = d[3:0];
  endtask

  // Holds iq_valid until the symbol is taken; caller drops valid when done.
  task automatic send_sym(input bit sel, input logic [7:0] d);
    int n = 0;
    op_t e;
    set_iq(d);
    if (sel) iq_valid1 = 1'b1; else iq_valid0 = 1'b1;
    @(negedge clk);
    while (!(sel ? iq_ready1 : iq_ready0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(sel ? iq_ready1 : iq_ready0)) fail_now("write accept");
    else begin
      e = '{we: 1'b1, addr: mptr[sel], data: d};
      if (sel) opq1.push_back(e); else opq0.push_back(e);
      mptr[sel] = mptr[sel] + 9'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [8:0] a, input logic [7:0] exp, input bit chk_lat);
    int n = 0;
    spi_rd_req0 = 1'b1;
    spi_rd_addr = a;
    opq0.push_back('{we: 1'b0, addr: a, data: 8'h00});
    rdq.push_back(exp);
    @(negedge clk);
    while (!spi_rd_ack0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!spi_rd_ack0) fail_now("read ack");
    else if (chk_lat) chk("read latency", n, 3);
    @(posedge clk);
    #1;
    spi_rd_req0 = 1'b0;
  endtask

  initial begin
    int wcnt, acks;
    bit acc;
    mptr[0] = 9'd0;
    mptr[1] = 9'd0;

    // Reset: iq_ready forced low even with a symbol offered.
    iq_valid0 = 1'b1;
    set_iq(8'hA5);
    @(negedge clk);
    chk("ready in reset", iq_ready0, 1'b0);
    chk("mem_en in reset", mem_en0, 1'b0);
    @(posedge clk); #1;
    iq_valid0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("reset count", wr_count0, 10'd0);
    chk("reset full/ovf", {store_full0, overflow0}, 2'b00);
    chk("reset spi", {spi_rd_ack0, spi_rd_data0}, 9'h000);
    chk("reset mem", {mem_en0, mem_we0, mem_addr0, mem_wdata0}, 19'h0);
    chk("reset ready", iq_ready0, 1'b1);
    chk("dut1 reset count", wr_count1, 10'd0);
    @(posedge clk); #1;

    // First symbol A/5 -> write of A5 at address 0.
    send_sym(1'b0, 8'hA5);
    iq_valid0 = 1'b0;
    @(negedge clk);
    chk("first write strobe", {mem_en0, mem_we0}, 2'b11);
    @(negedge clk);
    chk("count after first", wr_count0, 10'd1);
    @(posedge clk); #1;

    // Fill the non-wrapping store.
    for (int k = 1; k < 512; k++) send_sym(1'b0, 8'(k) ^ 8'h5A);
    iq_valid0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("full count", wr_count0, 10'd512);
    chk("store_full", store_full0, 1'b1);
    chk("ready when full", iq_ready0, 1'b0);
    chk("no overflow yet", overflow0, 1'b0);
    @(posedge clk); #1;
    iq_valid0 = 1'b1;
    @(posedge clk); #1;
    iq_valid0 = 1'b0;
    @(negedge clk);
    chk("overflow sticky", overflow0, 1'b1);
    chk("count held at full", wr_count0, 10'd512);
    @(posedge clk); #1;

    // Reads continue while full.
    do_read(9'h000, 8'hA5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("rd data held", spi_rd_data0, 8'hA5);
    @(posedge clk); #1;

    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    mptr[0] = 9'd0;
    @(negedge clk);
    chk("clear count", wr_count0, 10'd0);
    chk("clear full/ovf", {store_full0, overflow0}, 2'b00);
    chk("ready after clear", iq_ready0, 1'b1);
    @(posedge clk); #1;

    // Preloaded location readback.
    pre_we = 1'b1; pre_addr = 9'h07F; pre_data = 8'h3C;
    @(posedge clk); #1;
    pre_we = 1'b0;
    do_read(9'h07F, 8'h3C, 1'b1);
    @(negedge clk);
    chk("rd 7F held", spi_rd_data0, 8'h3C);
    @(posedge clk); #1;

    // Contention: expected order W R W R W.
    opq0.push_back('{we: 1'b1, addr: 9'd0, data: 8'h11});
    opq0.push_back('{we: 1'b0, addr: 9'h07F, data: 8'h00});
    opq0.push_back('{we: 1'b1, addr: 9'd1, data: 8'h22});
    opq0.push_back('{we: 1'b0, addr: 9'h07F, data: 8'h00});
    opq0.push_back('{we: 1'b1, addr: 9'd2, data: 8'h33});
    rdq.push_back(8'h3C);
    rdq.push_back(8'h3C);
    wcnt = 0;
    acks = 0;
    set_iq(8'h11);
    iq_valid0 = 1'b1;
    spi_rd_req0 = 1'b1;
    spi_rd_addr = 9'h07F;
    for (int c = 0; c < 60 && !(wcnt == 3 && acks == 2); c++) begin
      @(negedge clk);
      acc = iq_valid0 && iq_ready0;
      if (spi_rd_ack0) acks++;
      @(posedge clk); #1;
      if (acc) begin
        wcnt++;
        if (wcnt == 1) set_iq(8'h22);
        else if (wcnt == 2) set_iq(8'h33);
        else iq_valid0 = 1'b0;
      end
      if (acks == 2) spi_rd_req0 = 1'b0;
    end
    iq_valid0 = 1'b0;
    spi_rd_req0 = 1'b0;
    chk("contention writes", wcnt, 3);
    chk("contention acks", acks, 2);
    @(negedge clk);
    @(negedge clk);
    chk("count after contention", wr_count0, 10'd3);
    @(posedge clk); #1;

    // Wrapping instance: 513th symbol lands at address 0.
    for (int k = 0; k < 513; k++) send_sym(1'b1, 8'(k) ^ 8'hC3);
    iq_valid1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap count", wr_count1, 10'd512);
    chk("wrap full", store_full1, 1'b1);
    chk("wrap no overflow", overflow1, 1'b0);
    chk("wrap ready", iq_ready1, 1'b1);
    @(posedge clk); #1;

    // Reset during RD_WAIT abandons the read.
    spi_rd_req0 = 1'b1;
    spi_rd_addr = 9'h07F;
    opq0.push_back('{we: 1'b0, addr: 9'h07F, data: 8'h00});
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    spi_rd_req0 = 1'b0;
    #1;
    chk("rst mem_en", mem_en0, 1'b0);
    chk("rst rd data", spi_rd_data0, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    mptr[0] = 9'd0;
    mptr[1] = 9'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no ack after reset", spi_rd_ack0, 1'b0);
    end
    chk("idle after reset", iq_ready0, 1'b1);
    chk("count after reset", wr_count0, 10'd0);
    @(posedge clk); #1;

    // Reset while RD drives the RAM port: enable must drop immediately.
    spi_rd_req0 = 1'b1;
    spi_rd_addr = 9'h07F;
    @(posedge clk);
    #1;
    rst = 1'b1;
    spi_rd_req0 = 1'b0;
    #1;
    chk("rst mem_en in RD", mem_en0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_read(9'h07F, 8'h3C, 1'b1);

    repeat (3) @(negedge clk);
    chk("op queue drained", opq0.size(), 0);
    chk("rd queue drained", rdq.size(), 0);
    chk("dut1 queue drained", opq1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
